data_memory_ctrl: RTL and testbench

//  Byte-addressed data memory for the pipeline MEM stage. Supports byte/half/word loads and stores with

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_mem_align.sv | 63 ++++++
 rtl/data_memory_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, clear FSM
// states and the alignment rule applied to every CPU request.
package data_mem_pkg;

  localparam int NB_BYTE = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Half accesses must sit on an even byte, words on a word boundary;
  // the reserved size is never accepted.
  function automatic logic is_aligned(input size_e size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lsb[0];
      SIZE_WORD: return (lsb == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane steering for the data memory: builds the byte enables and shifted
// store data, and extracts/extends the addressed field of a loaded word.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_LANE = NB_DATA / NB_BYTE,
  parameter int NB_LSB  = $clog2(NB_LANE)
) (
  input  logic [NB_LSB-1:0]  lane,
  input  size_e              size,
  input  logic               is_unsigned,
  input  logic [NB_DATA-1:0] w_data,
  input  logic [NB_DATA-1:0] rd_word,
  output logic [NB_LANE-1:0] byte_en,
  output logic [NB_DATA-1:0] st_data,
  output logic [NB_DATA-1:0] ld_data
);

  logic [NB_LSB+2:0]  shift_s;
  logic [NB_DATA-1:0] field_s;
  logic               ext_s;

  assign shift_s = {lane, 3'b000};
  assign field_s = rd_word >> shift_s;
  assign st_data = w_data << shift_s;

  // Byte enables for the selected lane(s) of a store
  always_comb begin
    byte_en = {NB_LANE{1'b0}};
    case (size)
      SIZE_BYTE: byte_en = NB_LANE'(1'b1) << lane;
      SIZE_HALF: byte_en = NB_LANE'(2'b11) << lane;
      SIZE_WORD: byte_en = {NB_LANE{1'b1}};
      default:   byte_en = {NB_LANE{1'b0}};
    endcase
  end

  // Load field extraction with sign or zero extension from the field's top bit
  always_comb begin
    ext_s   = 1'b0;
    ld_data = {NB_DATA{1'b0}};
    case (size)
      SIZE_BYTE: begin
        ext_s   = ~is_unsigned & field_s[7];
        ld_data = {{(NB_DATA-8){ext_s}}, field_s[7:0]};
      end
      SIZE_HALF: begin
        ext_s   = ~is_unsigned & field_s[15];
        ld_data = {{(NB_DATA-16){ext_s}}, field_s[15:0]};
      end
      SIZE_WORD: begin
        ext_s   = 1'b0;
        ld_data = field_s;
      end
      default: begin
        ext_s   = 1'b0;
        ld_data = {NB_DATA{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores with a registered
// read, misalignment rejection, a hardware clear sequencer and a raw
// word-wide debug read port that stays live while clearing.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int N_WORDS  = 64,
  parameter int NB_WADDR = $clog2(N_WORDS),
  parameter int NB_ADDR  = NB_WADDR + $clog2(NB_DATA / 8)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rd_en,
  input  logic                i_wr_en,
  input  logic [NB_ADDR-1:0]  i_addr,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [NB_DATA-1:0]  i_w_data,
  input  logic                i_clear,
  input  logic [NB_WADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]  o_r_data,
  output logic                o_r_valid,
  output logic                o_misaligned,
  output logic                o_busy,
  output logic [NB_DATA-1:0]  o_dbg_data
);

  localparam int NB_LANE = NB_DATA / NB_BYTE;
  localparam int NB_LSB  = $clog2(NB_LANE);

  logic [NB_DATA-1:0]  mem_r [N_WORDS];
  state_e              state_r;
  logic [NB_WADDR-1:0] cnt_r;

  logic [NB_LSB-1:0]   lane_s;
  logic [NB_WADDR-1:0] waddr_s;
  size_e               size_s;
  logic                aligned_s;
  logic                req_s;
  logic                rd_ok_s;
  logic                wr_ok_s;
  logic                bad_s;
  logic [NB_LANE-1:0]  byte_en_s;
  logic [NB_DATA-1:0]  st_data_s;
  logic [NB_DATA-1:0]  ld_data_s;
  logic [NB_DATA-1:0]  rd_word_s;

  assign lane_s    = i_addr[NB_LSB-1:0];
  assign waddr_s   = i_addr[NB_ADDR-1:NB_LSB];
  assign size_s    = size_e'(i_size);
  assign aligned_s = is_aligned(size_s, i_addr[1:0]);
  // Requests are only honoured in IDLE and not on the cycle a clear starts
  assign req_s     = (i_rd_en | i_wr_en) & (state_r == ST_IDLE) & ~i_clear;
  assign rd_ok_s   = req_s & aligned_s & i_rd_en;
  assign wr_ok_s   = req_s & aligned_s & i_wr_en;
  assign bad_s     = req_s & ~aligned_s;
  assign rd_word_s = mem_r[waddr_s];

  data_mem_align #(
    .NB_DATA (NB_DATA)
  ) u_align (
    .lane        (lane_s),
    .size        (size_s),
    .is_unsigned (i_unsigned),
    .w_data      (i_w_data),
    .rd_word     (rd_word_s),
    .byte_en     (byte_en_s),
    .st_data     (st_data_s),
    .ld_data     (ld_data_s)
  );

  // Array update: clear sequencer zeroes one word per cycle, else byte-masked CPU store
  always_ff @(posedge i_clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= {NB_DATA{1'b0}};
    end else begin
      for (int i = 0; i < NB_LANE; i++) begin
        if (wr_ok_s && byte_en_s[i]) begin
          mem_r[waddr_s][i*NB_BYTE +: NB_BYTE] <= st_data_s[i*NB_BYTE +: NB_BYTE];
        end
      end
    end
  end

  // Clear FSM: reset or i_clear (re)starts the sweep at word 0; busy mirrors CLEAR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {NB_WADDR{1'b0}};
      o_busy  <= 1'b1;
    end else if (i_clear) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {NB_WADDR{1'b0}};
      o_busy  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (cnt_r == NB_WADDR'(N_WORDS - 1)) begin
            state_r <= ST_IDLE;
            cnt_r   <= {NB_WADDR{1'b0}};
            o_busy  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + NB_WADDR'(1);
          end
        end
        ST_IDLE: begin
          o_busy <= 1'b0;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {NB_WADDR{1'b0}};
          o_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Registered load result and status pulses; data holds when no load completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r_data     <= {NB_DATA{1'b0}};
      o_r_valid    <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (bad_s) begin
      o_r_data     <= {NB_DATA{1'b0}};
      o_r_valid    <= 1'b0;
      o_misaligned <= 1'b1;
    end else if (rd_ok_s) begin
      o_r_data     <= ld_data_s;
      o_r_valid    <= 1'b1;
      o_misaligned <= 1'b0;
    end else begin
      o_r_valid    <= 1'b0;
      o_misaligned <= 1'b0;
    end
  end

  // Debug port: raw word read every cycle, sees pre-store contents
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dbg_data <= {NB_DATA{1'b0}};
    end else begin
      o_dbg_data <= mem_r[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: load results go through a queue of
// expected values pushed at request time and popped when o_r_valid pulses.
module tb_data_memory_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_rd_en;
  logic        i_wr_en;
  logic [7:0]  i_addr;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_w_data;
  logic        i_clear;
  logic [5:0]  i_dbg_addr;
  logic [31:0] o_r_data;
  logic        o_r_valid;
  logic        o_misaligned;
  logic        o_busy;
  logic [31:0] o_dbg_data;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q [$];

  always #5 i_clk = ~i_clk;

  data_memory_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rd_en      (i_rd_en),
    .i_wr_en      (i_wr_en),
    .i_addr       (i_addr),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_w_data     (i_w_data),
    .i_clear      (i_clear),
    .i_dbg_addr   (i_dbg_addr),
    .o_r_data     (o_r_data),
    .o_r_valid    (o_r_valid),
    .o_misaligned (o_misaligned),
    .o_busy       (o_busy),
    .o_dbg_data   (o_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rd_en    = 1'b0;
    i_wr_en    = 1'b0;
    i_clear    = 1'b0;
    i_unsigned = 1'b0;
    i_size     = 2'b00;
    i_addr     = 8'h00;
    i_w_data   = 32'h0;
  endtask

  task automatic store(input logic [7:0] addr, input logic [1:0] size, input logic [31:0] data);
    i_wr_en  = 1'b1;
    i_addr   = addr;
    i_size   = size;
    i_w_data = data;
    step();
    idle_inputs();
    check("store_no_valid", {31'h0, o_r_valid}, 32'h0);
    check("store_no_misal", {31'h0, o_misaligned}, 32'h0);
  endtask

  task automatic load(input string tag, input logic [7:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    i_rd_en    = 1'b1;
    i_addr     = addr;
    i_size     = size;
    i_unsigned = uns;
    step();
    idle_inputs();
    check({tag, "_valid"}, {31'h0, o_r_valid}, 32'h1);
    if (o_r_valid === 1'b1) begin
      e = exp_q.pop_front();
      check(tag, o_r_data, e);
    end
  endtask

  task automatic reject(input string tag, input logic rd, input logic wr,
                        input logic [7:0] addr, input logic [1:0] size);
    i_rd_en  = rd;
    i_wr_en  = wr;
    i_addr   = addr;
    i_size   = size;
    i_w_data = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    check({tag, "_misal"}, {31'h0, o_misaligned}, 32'h1);
    check({tag, "_valid"}, {31'h0, o_r_valid}, 32'h0);
    check({tag, "_data"}, o_r_data, 32'h0);
  endtask

  task automatic dbg(input string tag, input logic [5:0] waddr, input logic [31:0] exp);
    i_dbg_addr = waddr;
    step();
    check(tag, o_dbg_data, exp);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'd64);
  endtask

  initial begin
    idle_inputs();
    i_dbg_addr = 6'd0;
    i_rst_n    = 1'b0;

    // 1: reset state, clear after release, array all zero
    step();
    check("rst_busy", {31'h0, o_busy}, 32'h1);
    check("rst_valid", {31'h0, o_r_valid}, 32'h0);
    check("rst_misal", {31'h0, o_misaligned}, 32'h0);
    check("rst_rdata", o_r_data, 32'h0);
    check("rst_dbg", o_dbg_data, 32'h0);
    step();
    i_rst_n = 1'b1;
    wait_clear("init_clear_len");
    for (int w = 0; w < 64; w++) dbg("init_zero", 6'(w), 32'h0);

    // 2: word store, signed and unsigned byte loads, other lanes
    store(8'h10, 2'b10, 32'hDEAD_BEEF);
    load("lb_13", 8'h13, 2'b00, 1'b0, 32'hFFFF_FFDE);
    load("lbu_10", 8'h10, 2'b00, 1'b1, 32'h0000_00EF);
    load("lb_11", 8'h11, 2'b00, 1'b0, 32'hFFFF_FFBE);
    load("lhu_12", 8'h12, 2'b01, 1'b1, 32'h0000_DEAD);
    load("lw_10", 8'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);

    // 3: half store merges into upper lanes only
    store(8'h20, 2'b10, 32'h1122_3344);
    store(8'h22, 2'b01, 32'h0000_8001);
    dbg("sh_merge", 6'd8, 32'h8001_3344);
    load("lh_22", 8'h22, 2'b01, 1'b0, 32'hFFFF_8001);
    load("lh_20", 8'h20, 2'b01, 1'b0, 32'h0000_3344);
    store(8'h21, 2'b00, 32'h0000_00A7);
    dbg("sb_merge", 6'd8, 32'h8001_A744);

    // 4: misaligned and reserved-size requests are rejected without writing
    reject("lw_11", 1'b1, 1'b0, 8'h11, 2'b10);
    reject("sh_23", 1'b0, 1'b1, 8'h23, 2'b01);
    reject("sz_11", 1'b1, 1'b0, 8'h20, 2'b11);
    reject("sw_22", 1'b0, 1'b1, 8'h22, 2'b10);
    step();
    check("misal_pulse_end", {31'h0, o_misaligned}, 32'h0);
    dbg("rej_w8", 6'd8, 32'h8001_A744);
    dbg("rej_w4", 6'd4, 32'hDEAD_BEEF);

    // 5: simultaneous load+store returns the old word
    store(8'h08, 2'b10, 32'h0000_0007);
    i_wr_en  = 1'b1;
    i_w_data = 32'h0000_0005;
    load("rbw_old", 8'h08, 2'b10, 1'b0, 32'h0000_0007);
    load("rbw_new", 8'h08, 2'b10, 1'b0, 32'h0000_0005);

    // 6: clear, reset mid-clear, restart via i_clear with a store ignored
    store(8'h3C, 2'b10, 32'hA5A5_A5A5);
    store(8'h84, 2'b10, 32'hCAFE_F00D);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("clr_busy", {31'h0, o_busy}, 32'h1);
    repeat (9) step();
    i_rd_en = 1'b1;
    i_addr  = 8'h10;
    i_size  = 2'b10;
    step();
    idle_inputs();
    check("clr_ld_valid", {31'h0, o_r_valid}, 32'h0);
    check("clr_ld_misal", {31'h0, o_misaligned}, 32'h0);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, o_busy}, 32'h1);
    check("mid_rst_rdata", o_r_data, 32'h0);
    step();
    i_rst_n = 1'b1;
    repeat (30) step();
    i_clear    = 1'b1;
    i_wr_en    = 1'b1;
    i_addr     = 8'h84;
    i_size     = 2'b10;
    i_w_data   = 32'h1234_5678;
    i_dbg_addr = 6'd33;
    step();
    idle_inputs();
    check("restart_busy", {31'h0, o_busy}, 32'h1);
    check("restart_valid", {31'h0, o_r_valid}, 32'h0);
    check("restart_misal", {31'h0, o_misaligned}, 32'h0);
    check("dbg_in_clear", o_dbg_data, 32'hCAFE_F00D);
    wait_clear("restart_clear_len");
    for (int w = 0; w < 64; w++) dbg("final_zero", 6'(w), 32'h0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
